// File: rtl/aui_seq_pkg.sv
// ============================================================================
//  Module      : aui_seq_pkg
//  Description : Shared state encoding and default constants for the AUI
//                link sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package aui_seq_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FLUSH     = 3'd1,
      WAIT_SYNC = 3'd2,
      RUN       = 3'd3,
      DONE      = 3'd4
   } seq_state_t;

   localparam int NUMBER_LANES = 16;
   localparam int BITS_BLOCK   = 257;

endpackage

`default_nettype wire

// File: rtl/aui_sat_counter.sv
// ============================================================================
//  Module      : aui_sat_counter
//  Description : Clearable up-counter that sticks at all-ones.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aui_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/aui_link_sequencer.sv
// ============================================================================
//  Module      : aui_link_sequencer
//  Description : Test-run controller: flush, wait for lane sync, run a fixed
//                number of compared blocks, report pass/fail.
//                Optional first-error capture: define AUI_SEQ_FIRST_ERR_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aui_link_sequencer
   import aui_seq_pkg::*;
#(
   parameter int NUMBER_LANES = aui_seq_pkg::NUMBER_LANES,
   parameter int FLUSH_CYCLES = 4,
   parameter int SYNC_TIMEOUT = 1024,
   parameter int RUN_BLOCKS   = 4096,
   parameter int CNT_W        = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic [NUMBER_LANES-1:0] i_sync_lane,
   input  logic                    i_blk_valid,
   input  logic                    i_blk_err,
   output logic                    o_dut_rst,
   output logic                    o_gen_en,
   output logic                    o_chk_en,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_pass,
   output logic                    o_timeout,
   output logic                    o_lock_lost,
   output logic [CNT_W-1:0]        o_blk_count,
   output logic [CNT_W-1:0]        o_err_count,
`ifdef AUI_SEQ_FIRST_ERR_EN
   output logic [CNT_W-1:0]        o_first_err_blk,
   output logic                    o_first_err_vld,
`endif
   output logic [2:0]              o_state
);

   localparam int TMR_MAX = (SYNC_TIMEOUT > FLUSH_CYCLES) ? SYNC_TIMEOUT : FLUSH_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] FLUSH_LAST = TMR_W'(FLUSH_CYCLES - 1);
   localparam logic [TMR_W-1:0] SYNC_LAST  = TMR_W'(SYNC_TIMEOUT - 1);
   // Wide compare so a narrow block counter can never alias the run length.
   localparam logic [63:0]      RUN_LIMIT  = 64'(RUN_BLOCKS);

   seq_state_t       state_q;
   logic [TMR_W-1:0] tmr_q;
   logic [CNT_W-1:0] blk_cnt_q;
   logic             dut_rst_q, gen_en_q, chk_en_q, busy_q, done_q, pass_q;
   logic             timeout_q, lock_q;

   logic             all_sync, start_ok, blk_take, err_take, run_full, pass_d;
   logic [CNT_W-1:0] blk_cnt_d, err_cnt;

   assign all_sync  = &i_sync_lane;
   assign start_ok  = i_start & ~i_abort & ((state_q == IDLE) | (state_q == DONE));
   assign blk_take  = i_blk_valid & ~i_abort & (state_q == RUN);
   assign err_take  = blk_take & i_blk_err;
   assign blk_cnt_d = blk_cnt_q + CNT_W'(blk_take);
   assign run_full  = blk_take & (64'(blk_cnt_d) == RUN_LIMIT);
   // The final block's error lands in the counter on the same edge as DONE.
   assign pass_d    = (err_cnt == '0) & ~err_take;

   aui_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (err_take),
      .clr_i   (start_ok),
      .count_o (err_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         blk_cnt_q <= '0;
         dut_rst_q <= 1'b0;
         gen_en_q  <= 1'b0;
         chk_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         lock_q    <= 1'b0;
      end else if (i_abort) begin
         state_q   <= IDLE;
         dut_rst_q <= 1'b0;
         gen_en_q  <= 1'b0;
         chk_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (i_start) begin
                  state_q   <= FLUSH;
                  tmr_q     <= '0;
                  blk_cnt_q <= '0;
                  timeout_q <= 1'b0;
                  lock_q    <= 1'b0;
                  done_q    <= 1'b0;
                  pass_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  dut_rst_q <= 1'b1;
               end
            end
            FLUSH: begin
               if (tmr_q == FLUSH_LAST) begin
                  state_q   <= WAIT_SYNC;
                  tmr_q     <= '0;
                  dut_rst_q <= 1'b0;
                  gen_en_q  <= 1'b1;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            WAIT_SYNC: begin
               if (all_sync) begin
                  state_q  <= RUN;
                  chk_en_q <= 1'b1;
               end else if (tmr_q == SYNC_LAST) begin
                  state_q   <= DONE;
                  timeout_q <= 1'b1;
                  gen_en_q  <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  pass_q    <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            RUN: begin
               blk_cnt_q <= blk_cnt_d;
               if (!all_sync || run_full) begin
                  state_q  <= DONE;
                  gen_en_q <= 1'b0;
                  chk_en_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  lock_q   <= ~all_sync;
                  pass_q   <= all_sync & pass_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef AUI_SEQ_FIRST_ERR_EN
   logic [CNT_W-1:0] first_blk_q;
   logic             first_vld_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first_blk_q <= '0;
         first_vld_q <= 1'b0;
      end else if (start_ok) begin
         first_blk_q <= '0;
         first_vld_q <= 1'b0;
      end else if (err_take && !first_vld_q) begin
         first_blk_q <= blk_cnt_q;
         first_vld_q <= 1'b1;
      end
   end

   assign o_first_err_blk = first_blk_q;
   assign o_first_err_vld = first_vld_q;
`endif

   assign o_dut_rst   = dut_rst_q;
   assign o_gen_en    = gen_en_q;
   assign o_chk_en    = chk_en_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_pass      = pass_q;
   assign o_timeout   = timeout_q;
   assign o_lock_lost = lock_q;
   assign o_blk_count = blk_cnt_q;
   assign o_err_count = err_cnt;
   assign o_state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_aui_link_sequencer.sv
// ============================================================================
//  Module      : tb_aui_link_sequencer
//  Description : Randomized scoreboard bench for aui_link_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_aui_link_sequencer;

   localparam int FLUSH   = 4;
   localparam int SYNC_TO = 64;
   localparam int RUN_B   = 100;

   typedef struct {
      int blk;
      int err;
      bit pass;
      bit tmo;
      bit lock;
      int ferr;
      bit fvld;
   } exp_t;

   logic        clk, rst;
   logic        start, abort, valid, err;
   logic [15:0] sync;
   logic        o_dut_rst, o_gen_en, o_chk_en, o_busy, o_done, o_pass, o_timeout, o_lock_lost;
   logic [31:0] o_blk_count, o_err_count;
   logic [2:0]  o_state;

   logic        s_start, s_abort, s_valid, s_err;
   logic [15:0] s_sync;
   logic        s_dut_rst, s_gen_en, s_chk_en, s_busy, s_done, s_pass, s_timeout, s_lock_lost;
   logic [3:0]  s_blk_count, s_err_count;
   logic [2:0]  s_state;
`ifdef AUI_SEQ_FIRST_ERR_EN
   logic [31:0] f_blk;
   logic        f_vld;
   logic [3:0]  s_f_blk;
   logic        s_f_vld;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   bit   errs[0:RUN_B-1];
   bit   done_prev;

   aui_link_sequencer #(
      .NUMBER_LANES(16), .FLUSH_CYCLES(FLUSH), .SYNC_TIMEOUT(SYNC_TO),
      .RUN_BLOCKS(RUN_B), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_sync_lane(sync),
      .i_blk_valid(valid), .i_blk_err(err), .o_dut_rst(o_dut_rst), .o_gen_en(o_gen_en),
      .o_chk_en(o_chk_en), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
      .o_timeout(o_timeout), .o_lock_lost(o_lock_lost), .o_blk_count(o_blk_count),
      .o_err_count(o_err_count),
`ifdef AUI_SEQ_FIRST_ERR_EN
      .o_first_err_blk(f_blk), .o_first_err_vld(f_vld),
`endif
      .o_state(o_state)
   );

   aui_link_sequencer #(
      .NUMBER_LANES(16), .FLUSH_CYCLES(FLUSH), .SYNC_TIMEOUT(SYNC_TO),
      .RUN_BLOCKS(20), .CNT_W(4)
   ) dut_sat (
      .clk(clk), .rst(rst), .i_start(s_start), .i_abort(s_abort), .i_sync_lane(s_sync),
      .i_blk_valid(s_valid), .i_blk_err(s_err), .o_dut_rst(s_dut_rst), .o_gen_en(s_gen_en),
      .o_chk_en(s_chk_en), .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
      .o_timeout(s_timeout), .o_lock_lost(s_lock_lost), .o_blk_count(s_blk_count),
      .o_err_count(s_err_count),
`ifdef AUI_SEQ_FIRST_ERR_EN
      .o_first_err_blk(s_f_blk), .o_first_err_vld(s_f_vld),
`endif
      .o_state(s_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference outcome of one run from its stimulus description.
   function automatic exp_t model(input int d, input int lock_at);
      exp_t e;
      int   n;
      e = '{blk: 0, err: 0, pass: 1'b0, tmo: 1'b0, lock: 1'b0, ferr: 0, fvld: 1'b0};
      if (d >= SYNC_TO) begin
         e.tmo = 1'b1;
         return e;
      end
      n      = (lock_at != 0) ? lock_at : RUN_B;
      e.lock = (lock_at != 0);
      e.blk  = n;
      for (int i = 0; i < n; i++) begin
         if (errs[i]) begin
            if (!e.fvld) begin
               e.fvld = 1'b1;
               e.ferr = i;
            end
            e.err++;
         end
      end
      e.pass = !e.lock && (e.err == 0);
      return e;
   endfunction

   // Monitor: every rising o_done retires one scoreboard entry.
   initial begin
      exp_t e;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && o_done && !done_prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("blk_count", o_blk_count, e.blk);
               chk("err_count", o_err_count, e.err);
               chk("pass", o_pass, e.pass);
               chk("timeout", o_timeout, e.tmo);
               chk("lock_lost", o_lock_lost, e.lock);
               chk("done_state", o_state, 4);
               chk("done_enables", {o_gen_en, o_chk_en, o_busy, o_dut_rst}, 0);
`ifdef AUI_SEQ_FIRST_ERR_EN
               chk("first_err_vld", f_vld, e.fvld);
               if (e.fvld) chk("first_err_blk", f_blk, e.ferr);
`endif
            end
         end
         done_prev = o_done;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish, expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] partial_sync();
      logic [15:0] v;
      v = 16'($urandom);
      v[$urandom_range(0, 15)] = 1'b0;
      return v;
   endfunction

   task automatic start_run(input int d, input logic [15:0] part, output bit ok);
      int hi;
      bit seen;
      ok   = 1'b0;
      hi   = 0;
      seen = 1'b0;
      sync = part;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (o_gen_en) begin
            seen = 1'b1;
            break;
         end
         if (o_dut_rst) hi++;
         @(negedge clk);
      end
      chk("flush_len", hi, FLUSH);
      if (!seen) begin
         chk("gen_en_seen", 0, 1);
         return;
      end
      if (d < SYNC_TO) begin
         repeat (d) @(negedge clk);
         sync = '1;
         seen = 1'b0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o_chk_en) begin
               seen = 1'b1;
               break;
            end
         end
         if (!seen) begin
            chk("chk_en_seen", 0, 1);
            return;
         end
      end
      ok = 1'b1;
   endtask

   task automatic send_blocks(input int lock_at);
      for (int i = 0; i < RUN_B; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         valid = 1'b1;
         err   = errs[i];
         if (lock_at == i + 1) sync[3] = 1'b0;
         @(negedge clk);
         valid = 1'b0;
         err   = 1'b0;
         if (lock_at == i + 1) break;
      end
   endtask

   task automatic wait_done();
      for (int k = 0; k < 200; k++) begin
         if (o_done) break;
         @(negedge clk);
      end
      if (!o_done) chk("done_seen", 0, 1);
      sync = '0;
      @(negedge clk);
   endtask

   task automatic run_case(input int d, input int lock_at);
      bit ok;
      sb.push_back(model(d, lock_at));
      start_run(d, partial_sync(), ok);
      if (ok && d < SYNC_TO) send_blocks(lock_at);
      wait_done();
   endtask

   task automatic pump(input int n);
      for (int i = 0; i < n; i++) begin
         valid = 1'b1;
         @(negedge clk);
      end
      valid = 1'b0;
   endtask

   initial begin
      bit ok;
      rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; err = 1'b0; sync = '0;
      s_start = 1'b0; s_abort = 1'b0; s_valid = 1'b0; s_err = 1'b0; s_sync = '0;
      repeat (2) @(negedge clk);
      chk("rst_state", o_state, 0);
      chk("rst_flags", {o_dut_rst, o_gen_en, o_chk_en, o_busy, o_done, o_pass, o_timeout, o_lock_lost}, 0);
      chk("rst_counts", {o_blk_count, o_err_count}, 0);
      rst = 1'b1;
      @(negedge clk);

      foreach (errs[i]) errs[i] = 1'b0;
      run_case(10, 0);
      errs[4] = 1'b1; errs[49] = 1'b1; errs[99] = 1'b1;
      run_case(10, 0);
      foreach (errs[i]) errs[i] = 1'b0;
      sb.push_back(model(SYNC_TO, 0));
      start_run(SYNC_TO, 16'h7FFF, ok);
      wait_done();
      run_case(3, 41);

      for (int r = 0; r < 6; r++) begin
         int d, lk;
         foreach (errs[i]) errs[i] = ($urandom_range(0, 49) == 0);
         d  = ($urandom_range(0, 7) == 0) ? SYNC_TO + $urandom_range(0, 5) : $urandom_range(0, 40);
         lk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, RUN_B) : 0;
         run_case(d, lk);
      end

      // Abort mid-run with a simultaneous start; a stray start in RUN is ignored.
      foreach (errs[i]) errs[i] = 1'b0;
      start_run(0, partial_sync(), ok);
      pump(10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pump(10);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("abort_state", o_state, 0);
      chk("abort_blk_hold", o_blk_count, 20);
      chk("abort_outputs", {o_dut_rst, o_gen_en, o_chk_en, o_busy, o_done, o_pass}, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_blk_clr", o_blk_count, 0);
      chk("restart_state", o_state, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_flush", o_state, 0);

      // Asynchronous reset pulse between clock edges.
      start_run(0, partial_sync(), ok);
      pump(5);
      #2 rst = 1'b0;
      #0.5;
      chk("arst_state", o_state, 0);
      chk("arst_flags", {o_dut_rst, o_gen_en, o_chk_en, o_busy, o_done, o_pass, o_timeout, o_lock_lost}, 0);
      chk("arst_counts", {o_blk_count, o_err_count}, 0);
      #0.5 rst = 1'b1;
      sync = '0;
      @(negedge clk);

      // 4-bit error counter saturation.
      s_sync  = '1;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (s_chk_en) break;
         @(negedge clk);
      end
      chk("sat_chk_en", s_chk_en, 1);
      s_valid = 1'b1; s_err = 1'b1;
      repeat (10) @(negedge clk);
      s_valid = 1'b0;
      @(negedge clk);
      chk("sat_err_10", s_err_count, 10);
      s_valid = 1'b1;
      repeat (10) @(negedge clk);
      s_valid = 1'b0; s_err = 1'b0;
      @(negedge clk);
      chk("sat_err_20", s_err_count, 15);
      s_abort = 1'b1;
      @(negedge clk);
      s_abort = 1'b0;
      chk("sat_abort_state", s_state, 0);

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
